// File: rtl/riscv_pkg.sv
// Shared core-wide constants: datapath width, register file geometry, port counts.
package riscv_pkg;
    localparam int DATA_WIDTH    = 32;
    localparam int REG_FILE_SIZE = 32;
    localparam int REG_ADDR_BITS = $clog2(REG_FILE_SIZE);
    localparam int NUM_RD_PORTS  = 2;
    localparam int NUM_WR_PORTS  = 1;
endpackage

// File: rtl/regfile_wr_arb.sv
// Per-register write resolution: which registers are written this cycle and with what data.
// Highest-indexed enabled port wins on an address collision; x0 is never selected.
module regfile_wr_arb #(
    parameter int NUM_REGS = 32,
    parameter int NUM_WR   = 1,
    parameter int AW       = 5,
    parameter int DW       = 32
) (
    input  logic [NUM_WR-1:0]                 wr_en_i,
    input  logic [NUM_WR*AW-1:0]              wr_addr_i,
    input  logic [NUM_WR*DW-1:0]              wr_data_i,
    output logic [NUM_REGS-1:0]               we_o,
    output logic [NUM_REGS-1:0][DW-1:0]       wd_o
);
    always_comb begin
        we_o = '0;
        wd_o = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            // ascending scan so the last (highest) matching port overrides
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] == AW'(r))) begin
                    we_o[r] = 1'b1;
                    wd_o[r] = wr_data_i[w*DW +: DW];
                end
            end
        end
    end
endmodule

// File: rtl/regfile_sb.sv
// Multi-ported register file with per-register busy (scoreboard) bits and
// optional same-cycle write-to-read forwarding.
module regfile_sb #(
    parameter int DATA_WIDTH = riscv_pkg::DATA_WIDTH,
    parameter int NUM_REGS   = riscv_pkg::REG_FILE_SIZE,
    parameter int NUM_RD     = riscv_pkg::NUM_RD_PORTS,
    parameter int NUM_WR     = riscv_pkg::NUM_WR_PORTS,
    parameter int BYPASS     = 1,
    localparam int AW        = $clog2(NUM_REGS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_RD*AW-1:0]         rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]            rd_busy,
    input  logic [NUM_WR-1:0]            wr_en,
    input  logic [NUM_WR*AW-1:0]         wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
    input  logic                         rsv_en,
    input  logic [AW-1:0]                rsv_addr,
    input  logic                         flush
);
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;
    logic [NUM_REGS-1:0]                 busy_q, busy_d;
    logic [NUM_REGS-1:0]                 we;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] wd;

    regfile_wr_arb #(
        .NUM_REGS (NUM_REGS),
        .NUM_WR   (NUM_WR),
        .AW       (AW),
        .DW       (DATA_WIDTH)
    ) u_arb (
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .we_o      (we),
        .wd_o      (wd)
    );

    // priority: flush > new reservation > completing write > hold
    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (we[r])
                busy_d[r] = 1'b0;
            if (rsv_en && (rsv_addr == AW'(r)))
                busy_d[r] = 1'b1;
        end
        if (flush)
            busy_d = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (we[r])
                    regs_q[r] <= wd[r];
            end
            busy_q <= busy_d;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0] ra;
        logic          fwd;
        assign ra  = rd_addr[p*AW +: AW];
        assign fwd = (BYPASS != 0) && we[ra];
        // rst_n gate keeps a forwarded write from leaking out during reset
        assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] =
            !rst_n ? '0 : (fwd ? wd[ra] : regs_q[ra]);
        assign rd_busy[p] = rst_n && busy_q[ra] && !fwd;
    end
endmodule
